// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with synchronous load (clamped to N-1), zero-latency terminal count
// and a registered wrap pulse. Define MODN_SAT_EN to saturate at 0 / N-1 instead of wrapping.
module mod_n_updown_counter #(
  parameter int unsigned N = 10,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         wrap
);

  localparam int unsigned LpW1 = W + 1;
  localparam logic [W-1:0] LpMax = W'(N - 1);
  localparam logic [W:0] LpN = LpW1'(N);

  logic [W-1:0] r_q;
  logic         r_wrap;

  logic         w_at_max;
  logic         w_at_zero;
  logic         w_term;
  logic [W-1:0] w_load_val;
  logic [W-1:0] w_q_nxt;
  logic         w_wrap_nxt;

  always_comb begin
    w_at_max   = (r_q == LpMax);
    w_at_zero  = (r_q == '0);
    w_term     = up ? w_at_max : w_at_zero;
    // Out-of-range load values are clamped so q never leaves 0..N-1.
    w_load_val = ({1'b0, d} >= LpN) ? LpMax : d;
  end

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (load) begin
      w_q_nxt = w_load_val;
    end else if (en) begin
      if (up) begin
        if (w_at_max) begin
`ifdef MODN_SAT_EN
          w_q_nxt    = r_q;
`else
          w_q_nxt    = '0;
          w_wrap_nxt = 1'b1;
`endif
        end else begin
          w_q_nxt = r_q + W'(1);
        end
      end else begin
        if (w_at_zero) begin
`ifdef MODN_SAT_EN
          w_q_nxt    = r_q;
`else
          w_q_nxt    = LpMax;
          w_wrap_nxt = 1'b1;
`endif
        end else begin
          w_q_nxt = r_q - W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign tc   = en & w_term;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed self-checking bench for mod_n_updown_counter (N=10, W=4); honours MODN_SAT_EN.
module tb_mod_n_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] d = 4'd0;
  logic [3:0] q;
  logic       tc;
  logic       wrap;

  int checks = 0;
  int failures = 0;

  mod_n_updown_counter #(.N(10), .W(4)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .up  (up),
    .load(load),
    .d   (d),
    .q   (q),
    .tc  (tc),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then land on the following falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state, with load/en high during reset.
    @(negedge clk);
    check("rst_q", int'(q), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_tc_en0", int'(tc), 0);
    en = 1'b1; up = 1'b0; load = 1'b1; d = 4'd5;
    #1;
    check("rst_tc_down", int'(tc), 1);
    step();
    check("rst_hold_q", int'(q), 0);
    check("rst_hold_wrap", int'(wrap), 0);

    // Release and count up 1,2,3.
    rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    step(); check("up_q1", int'(q), 1);
    step(); check("up_q2", int'(q), 2);
    step(); check("up_q3", int'(q), 3);
    step(); step(); step(); step();
    check("up_q7", int'(q), 7);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check("async_rst_q", int'(q), 0);
    check("async_rst_wrap", int'(wrap), 0);
    @(negedge clk);
    rst = 1'b0;
    step(); check("post_rst_q1", int'(q), 1);

    // Load priority and clamp.
    load = 1'b1; en = 1'b1; d = 4'd4;
    step();
    check("load4_q", int'(q), 4);
    check("load4_wrap", int'(wrap), 0);
    d = 4'd13;
    step(); check("load13_clamp", int'(q), 9);
    d = 4'd9; en = 1'b0;
    step();
    check("load9_q", int'(q), 9);
    check("load9_wrap", int'(wrap), 0);
    check("load9_tc", int'(tc), 0);
    en = 1'b1; up = 1'b1;
    #1; check("load_term_tc", int'(tc), 1);
    step(); check("load_term_nowrap", int'(wrap), 0);
    check("load_term_q", int'(q), 9);

    // Up at terminal value.
    load = 1'b0;
    check("upterm_tc", int'(tc), 1);
`ifdef MODN_SAT_EN
    step();
    check("sat_up_q_a", int'(q), 9); check("sat_up_wrap_a", int'(wrap), 0);
    check("sat_up_tc_a", int'(tc), 1);
    step();
    check("sat_up_q_b", int'(q), 9); check("sat_up_wrap_b", int'(wrap), 0);
    step();
    check("sat_up_q_c", int'(q), 9); check("sat_up_tc_c", int'(tc), 1);
    load = 1'b1; d = 4'd0;
    step();
    load = 1'b0; up = 1'b0;
    #1; check("sat_dn_tc", int'(tc), 1);
    step();
    check("sat_dn_q_a", int'(q), 0); check("sat_dn_wrap_a", int'(wrap), 0);
    step();
    check("sat_dn_q_b", int'(q), 0);
`else
    step();
    check("upwrap_q", int'(q), 0);
    check("upwrap_wrap", int'(wrap), 1);
    step();
    check("upwrap_q1", int'(q), 1);
    check("upwrap_wrap_clr", int'(wrap), 0);

    // Down wrap from 0.
    load = 1'b1; d = 4'd0;
    step();
    load = 1'b0; up = 1'b0;
    #1; check("dnwrap_tc", int'(tc), 1);
    step();
    check("dnwrap_q", int'(q), 9);
    check("dnwrap_wrap", int'(wrap), 1);
    step();
    check("dnwrap_q8", int'(q), 8);
    check("dnwrap_wrap_clr", int'(wrap), 0);

    // Reset clears a pending wrap pulse.
    load = 1'b1; d = 4'd0;
    step();
    load = 1'b0;
    step();
    check("pend_wrap", int'(wrap), 1);
    rst = 1'b1;
    #1;
    check("pend_wrap_clr", int'(wrap), 0);
    check("pend_q_clr", int'(q), 0);
    @(negedge clk);
    rst = 1'b0;
`endif

    // Direction change and hold.
    load = 1'b1; d = 4'd3; en = 1'b1; up = 1'b1;
    step();
    load = 1'b0;
    step(); check("dir_q4", int'(q), 4);
    up = 1'b0;
    step(); check("dir_q3", int'(q), 3);
    en = 1'b0;
    step(); step(); step();
    check("hold_q", int'(q), 3);
    check("hold_tc", int'(tc), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mod_n_updown_counter.md
MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 SHALL have parameter N, default 10: counter modulus, legal range 2..2^W.
REQ-002 SHALL have parameter W, default 4: count width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1: count enable.
REQ-006 SHALL have port up, input, 1: direction; 1 = increment, 0 = decrement.
REQ-007 SHALL have port load, input, 1: synchronous parallel load strobe.
REQ-008 SHALL have port d, input, W: load value.
REQ-009 SHALL have port q, output, W: registered count value, always within 0..N-1.
REQ-010 SHALL have port tc, output, 1: combinational terminal count; en=1 and q at the terminal value for the current direction.
REQ-011 SHALL have port wrap, output, 1: registered one-cycle pulse marking a wrap-around.

Function
REQ-012 SHALL apply priority rst > load > en per rising edge.
REQ-013 SHALL set q to d on load=1, regardless of en and up.
REQ-014 SHALL clamp a load value d >= N to q = N-1.
REQ-015 SHALL hold q when load=0 and en=0.
REQ-016 SHALL set q to q+1 when en=1 and up=1 with q < N-1.
REQ-017 SHALL set q to q-1 when en=1 and up=0 with q > 0.
REQ-018 SHALL wrap q from N-1 to 0 on en=1 and up=1.
REQ-019 SHALL wrap q from 0 to N-1 on en=1 and up=0.
REQ-020 SHALL define the terminal value as N-1 when up=1 and 0 when up=0; tc follows same-cycle up, en and q with zero latency.
REQ-021 SHALL assert wrap for exactly the one cycle after a wrapping edge and deassert it on every other edge.
REQ-022 SHALL give a wrap-around edge no extra latency: the new q is visible after the same edge.
REQ-023 SHALL not assert wrap on load, even when load lands on the terminal value.
REQ-024 SHALL take the new direction on the next edge when up changes mid-count; there are no hidden states.
REQ-025 SHALL keep the counting datapath W bits wide; no intermediate value outside 0..N-1 SHALL ever reach q.

Reset
REQ-026 SHALL force q=0 and wrap=0 immediately on rst=1, without waiting for clk.
REQ-027 SHALL hold q=0 and wrap=0 while rst=1, including when load or en is high.
REQ-028 SHALL resume normal operation on the first rising edge after rst falls.
REQ-029 SHALL leave tc combinational during reset: tc=1 when en=1 and up=0, since q=0.
REQ-030 SHALL clear any pending wrap pulse when reset is asserted mid-operation.

Configuration
REQ-031 SHALL support macro MODN_SAT_EN to select saturating mode.
REQ-032 When MODN_SAT_EN is defined:
- q holds at N-1 when counting up from N-1, and holds at 0 when counting down from 0.
- wrap SHALL be tied to 0.
- tc behaviour is unchanged.
REQ-033 When MODN_SAT_EN is not defined, wrap-around behaviour per REQ-018/019/021 applies.

Verification (N=10, W=4)
REQ-034 Reset: assert rst between clock edges while q=7 -> q=0 and wrap=0 immediately; en=1 and up=1 after release -> q=1,2,3 on successive edges.
REQ-035 Up wrap: q=9, en=1, up=1 -> tc=1 before the edge; q=0 and wrap=1 for one cycle after it; q=1 and wrap=0 on the next edge.
REQ-036 Down wrap: q=0, en=1, up=0 -> tc=1; then q=9 and wrap=1; then q=8.
REQ-037 Load priority and clamp: load=1, en=1, d=4 -> q=4 and wrap=0; d=13 -> q=9; d=9 with en=0 -> q=9, wrap=0, tc=0.
REQ-038 Direction and hold: count 3 -> 4, then up=0 -> 3, then en=0 for 3 cycles -> q stays 3 and tc=0.
REQ-039 With MODN_SAT_EN: q=9, up=1, en=1 for 3 edges -> q stays 9, wrap stays 0, tc=1; up=0 from q=0 -> q stays 0.
